// File: rtl/sng_window_pkg.sv
// Shared types and constants for the stochastic number generator window.
package sng_window_pkg;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ENDW = 2'd2
  } state_e;

  // Maximal-length Fibonacci LFSR tap masks, bit k set means stage k+1 feeds back.
  // N=8 is x^8+x^6+x^5+x^4+1.
  function automatic logic [31:0] lfsr_taps(input int n);
    logic [31:0] taps;
    case (n)
      2:       taps = 32'h0000_0003;
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      default: taps = 32'h0000_00B8;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/sng_window_lfsr_gen.sv
// N-bit maximal-length LFSR; visits every nonzero state once per 2^N-1 steps.
module lfsr_gen
  import sng_window_pkg::*;
#(
  parameter int           N    = 8,
  parameter logic [N-1:0] SEED = 'h01
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ENABLE,
  output logic [N-1:0] state
);

  localparam logic [31:0]  TAPS_ALL = lfsr_taps(N);
  localparam logic [N-1:0] TAPS     = TAPS_ALL[N-1:0];

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;

  // Shift in the parity of the tapped stages when enabled.
  always_comb begin
    state_d = state_q;
    if (ENABLE) begin
      state_d = {state_q[N-2:0], ^(state_q & TAPS)};
    end
  end

  // State register; reset reloads the seed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/sng_window.sv
// Stochastic bitstream generator: emits exactly value_reg ones over a
// 2^N-1 cycle window by comparing a full-period LFSR against the target.
//
// state | meaning
// IDLE  | waiting for a load, ready high
// RUN   | window in progress, one bit per enabled cycle
// ENDW  | one-cycle window-end strobe (preRESET), accepts back-to-back load
module sng_window
  import sng_window_pkg::*;
#(
  parameter int           N       = 8,
  parameter int           N_count = 8,
  parameter logic [N-1:0] SEED    = 'h01
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ENABLE,
  input  logic         load,
  input  logic [N-1:0] value_in,
  output logic         ready,
  output logic         out,
  output logic         preRESET,
  output logic         busy
);

  // Counter value on the last bit of a window (WIN-1, WIN = 2^N-1).
  localparam logic [N_count-1:0] LAST = N_count'((2 ** N) - 2);

  state_e               state_q, state_d;
  logic [N-1:0]         value_q, value_d;
  logic [N_count-1:0]   cnt_q, cnt_d;
  logic [N-1:0]         lfsr;
  logic                 accept;
  logic                 step_en;
  logic                 last_bit;

  // The LFSR free-runs on ENABLE and is never reseeded between windows;
  // any 2^N-1 consecutive steps still cover every nonzero value once.
  lfsr_gen #(
    .N    (N),
    .SEED (SEED)
  ) u_lfsr (
    .CLK    (CLK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .state  (lfsr)
  );

  assign accept   = load && (state_q != RUN);
  assign step_en  = (state_q == RUN) && ENABLE;
  assign last_bit = step_en && (cnt_q == LAST);

  // Next-state logic for the window FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_bit) state_d = ENDW;
      ENDW:    state_d = load ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Target capture on accepted load; counter counts enabled RUN cycles.
  always_comb begin
    value_d = value_q;
    cnt_d   = cnt_q;
    if (accept) begin
      value_d = value_in;
      cnt_d   = '0;
    end else if (step_en) begin
      cnt_d = cnt_q + N_count'(1);
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced to their idle values while RESET is asserted.
  always_comb begin
    ready    = RESET || (state_q != RUN);
    busy     = !RESET && (state_q == RUN);
    preRESET = !RESET && (state_q == ENDW);
    out      = !RESET && step_en && (lfsr <= value_q);
  end

endmodule

// File: tb/tb_sng_window.sv
// Randomized self-checking bench for sng_window: counts ones and enabled
// cycles per window and compares against the target value and window length.
module tb_sng_window;

  localparam int         N    = 8;
  localparam int         WIN  = (1 << N) - 1;
  localparam logic [7:0] SEED = 8'h01;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] value_in;
  logic       ready;
  logic       out;
  logic       pre;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int mean_acc = 0;
  int mean_out = 0;

  always #5 clk = ~clk;

  sng_window #(
    .N       (N),
    .N_count (8),
    .SEED    (SEED)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .ENABLE   (en),
    .load     (load),
    .value_in (value_in),
    .ready    (ready),
    .out      (out),
    .preRESET (pre),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs on the falling edge, sample outputs 1ns later.
  // Also models the downstream mean stage: count ones, latch on preRESET.
  task automatic step(input bit r, input bit ld, input bit e, input logic [7:0] v);
    @(negedge clk);
    rst = r; load = ld; en = e; value_in = v;
    #1;
    if (r) begin
      mean_acc = 0;
    end else if (pre) begin
      mean_out = mean_acc;
      mean_acc = 0;
    end else if (out) begin
      mean_acc++;
    end
  endtask

  function automatic bit rnd_en(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  task automatic start(input logic [7:0] v, input string tag);
    step(0, 1, 1, v);
    chk({tag, "_ready_at_load"}, ready, 1);
  endtask

  // Runs until preRESET (inclusive), counting stream statistics.
  task automatic body(input bit ld_hold, input logic [7:0] v, input int pct, input string tag,
                      output int ones, output int en_cyc, output int cyc, output bit first_busy);
    int bad;
    bit e;
    bit got_pre;
    bad = 0; ones = 0; en_cyc = 0; cyc = 0; first_busy = 0; got_pre = 0;
    for (int i = 0; i < 3000; i++) begin
      e = rnd_en(pct);
      step(0, ld_hold, e, v);
      cyc++;
      if (i == 0) first_busy = busy;
      if (pre) begin
        got_pre = 1;
        if (out) bad++;
        break;
      end
      if (!busy) bad++;
      if (busy && ready) bad++;
      if (busy && e) begin
        en_cyc++;
        if (out) ones++;
      end else if (out) begin
        bad++;
      end
    end
    chk({tag, "_prereset_seen"}, got_pre, 1);
    chk({tag, "_protocol"}, bad, 0);
  endtask

  task automatic full_window(input logic [7:0] v, input int pct, input string tag);
    int ones, en_cyc, cyc;
    bit fb;
    start(v, tag);
    body(0, v, pct, tag, ones, en_cyc, cyc, fb);
    chk({tag, "_ones"}, ones, v);
    chk({tag, "_en_cycles"}, en_cyc, WIN);
    chk({tag, "_mean"}, mean_out, v);
    if (pct >= 100) chk({tag, "_latency"}, cyc, WIN + 1);
  endtask

  task automatic idle_check(input string tag);
    step(0, 0, 1, 8'd0);
    chk({tag, "_pre_one_cycle"}, pre, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_ready"}, ready, 1);
  endtask

  initial begin
    int ones, en_cyc, cyc, pres;
    bit fb;
    logic [7:0] rv;
    rst = 1; load = 0; en = 0; value_in = 0;

    step(1, 0, 0, 8'd0);
    step(1, 1, 1, 8'hFF);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out", out, 0);
    chk("rst_pre", pre, 0);
    step(0, 0, 0, 8'd0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", ready, 1);

    full_window(8'd100, 100, "w100");
    idle_check("w100");
    full_window(8'd0, 100, "w0");
    idle_check("w0");
    full_window(8'd255, 100, "w255");
    idle_check("w255");
    full_window(8'd64, 50, "w64_half");
    idle_check("w64_half");

    // Back-to-back: load held high, 20 presented during RUN is ignored.
    start(8'd10, "b2b");
    body(1, 8'd20, 100, "b2b1", ones, en_cyc, cyc, fb);
    chk("b2b1_ones", ones, 10);
    chk("b2b1_len", cyc, WIN + 1);
    body(0, 8'd20, 100, "b2b2", ones, en_cyc, cyc, fb);
    chk("b2b2_no_gap", fb, 1);
    chk("b2b2_ones", ones, 20);
    chk("b2b2_len", cyc, WIN + 1);
    idle_check("b2b");

    // Reset mid-window at enabled cycle 120, with load/ENABLE also high.
    start(8'd150, "midrst");
    for (int i = 0; i < 120; i++) step(0, 0, 1, 8'd150);
    chk("midrst_busy_before", busy, 1);
    step(1, 1, 1, 8'd77);
    chk("midrst_out", out, 0);
    chk("midrst_pre", pre, 0);
    chk("midrst_busy", busy, 0);
    step(0, 0, 0, 8'd0);
    chk("midrst_ready", ready, 1);
    chk("midrst_busy_after", busy, 0);
    chk("midrst_lfsr_seed", dut.u_lfsr.state, SEED);
    pres = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 1, 8'd0);
      if (pre || busy) pres++;
    end
    chk("midrst_no_prereset", pres, 0);

    // Chained mean stage over three back-to-back windows.
    start(8'd37, "chain");
    body(1, 8'd200, 70, "chain37", ones, en_cyc, cyc, fb);
    chk("chain37_mean", mean_out, 37);
    body(1, 8'd1, 70, "chain200", ones, en_cyc, cyc, fb);
    chk("chain200_mean", mean_out, 200);
    body(0, 8'd1, 70, "chain1", ones, en_cyc, cyc, fb);
    chk("chain1_mean", mean_out, 1);
    idle_check("chain");

    // Random targets with random ENABLE density.
    for (int k = 0; k < 4; k++) begin
      rv = 8'($urandom_range(255, 0));
      full_window(rv, int'($urandom_range(100, 30)), $sformatf("rnd%0d_v%0d", k, rv));
      if ($urandom_range(1, 0) == 1) idle_check($sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sng_window.md
SNG_WINDOW -- requirements
Module: sng_window

Interface
REQ-001 Parameter N, default 8: binary value precision and LFSR width.
REQ-002 Parameter N_count, default 8: window counter width; N_count >= N is required.
REQ-003 Parameter SEED, default 8'h01: LFSR reset value; nonzero is required.
REQ-004 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 ENABLE  input  1  stream advance qualifier; low freezes counter and LFSR.
REQ-007 load  input  1  request to start a window with value_in.
REQ-008 value_in  input  N  unsigned target ones-count per window.
REQ-009 ready  output  1  high when a load is accepted this cycle.
REQ-010 out  output  1  stochastic bitstream to the downstream MEAN stage "in" port.
REQ-011 preRESET  output  1  one-cycle window-end strobe to the downstream MEAN stage "preRESET" port.
REQ-012 busy  output  1  high while a window is in progress.

Function
REQ-013 Window length SHALL be WIN = 2^N - 1 enabled cycles, equal to one full LFSR period.
REQ-014 LFSR SHALL be N-bit, maximal-length, with nonzero states only (N=8 taps: x^8+x^6+x^5+x^4+1).
REQ-015 out SHALL be (lfsr <= value_reg) during RUN with ENABLE high, and 0 otherwise.
REQ-016 Ones in any complete window SHALL equal value_reg exactly: 0 gives none, 2^N-1 gives all.
REQ-017 States SHALL be IDLE, RUN and ENDW.
REQ-018 ready SHALL be 1 in IDLE and ENDW and 0 in RUN.
REQ-019 busy SHALL be 1 only in RUN.
REQ-020 When load and ready are both high, value_reg SHALL capture value_in, the counter SHALL clear to 0, and the next state SHALL be RUN.
REQ-021 In RUN with ENABLE high, the block SHALL emit one bit, advance the LFSR one step, and increment the counter.
REQ-022 In RUN with ENABLE low, out SHALL be 0 and the counter and LFSR SHALL hold.
REQ-023 When an enabled RUN cycle has counter == WIN-1, the next state SHALL be ENDW.
REQ-024 In ENDW, preRESET SHALL be 1 for exactly one cycle and out SHALL be 0.
REQ-025 From ENDW, a load SHALL go to RUN (back-to-back windows, no idle gap); with no load, the next state SHALL be IDLE.
REQ-026 load during RUN SHALL be ignored, and value_reg SHALL be unchanged.
REQ-027 The LFSR SHALL NOT be reseeded per window; it free-runs across windows while enabled.
REQ-028 Latency: the first stream bit SHALL appear the cycle after load is accepted, and preRESET the cycle after the last bit.

Reset
REQ-029 RESET SHALL set state to IDLE, lfsr to SEED, counter to 0 and value_reg to 0.
REQ-030 During RESET, out, preRESET and busy SHALL be 0 and ready SHALL be 1.
REQ-031 RESET mid-window SHALL abort the window with no preRESET emitted.
REQ-032 RESET SHALL take priority over load and ENABLE in the same cycle.

Structure
REQ-033 A shared package SHALL hold the state enum {IDLE, RUN, ENDW} and the LFSR tap constants per N.
REQ-034 One sub-module, lfsr_gen, SHALL be used, with ports CLK, RESET, ENABLE, state[N-1:0] and parameters N and SEED.
REQ-035 The comparator and control FSM SHALL reside in sng_window.

Verification
REQ-036 Reset, then load value_in=8'd100 with ENABLE held high: exactly 100 ones in 255 cycles, then preRESET=1 for 1 cycle.
REQ-037 value_in=0 and value_in=255: 0 ones and 255 ones respectively; preRESET at cycle 256 after load.
REQ-038 ENABLE toggled at 50% during a value_in=64 window: still 64 ones, and preRESET arrives after 255 enabled cycles.
REQ-039 load asserted throughout, value 10 then 20: the second window starts the cycle after preRESET, and the 20 applied during RUN is ignored until ENDW.
REQ-040 RESET asserted at enabled cycle 120 of a window: no preRESET, ready=1, lfsr==SEED on the next cycle.
REQ-041 Chained with the downstream MEAN stage (START=0): its latched out equals value_in for three consecutive windows with values 37, 200 and 1.
